// File: rtl/ser_pkg.sv
// Shared types and sizing for the stream serializer.
// Bit-counter width leaves room for the extra parity position (SER_PARITY_EN).
package ser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 16;

   function automatic int bitcnt_w(input int width);
      return $clog2(width + 1);
   endfunction

   localparam int DEF_BITCNT_W = bitcnt_w(DEF_WIDTH);

endpackage

// File: rtl/ser_pend_slot.sv
// One-entry holding register with valid flag; take and load may coincide.
// Reusable as a skid slot in front of any single-word consumer.
module ser_pend_slot
   import ser_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_take,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_ready
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (i_take) valid_d = 1'b0;
      if (i_load) begin
         data_d  = i_data;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_ready = ~valid_q;

endmodule

// File: rtl/stream_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in, MSB-first bit stream out.
// Build option SER_PARITY_EN appends an even-parity bit after each word.
//
//   state | meaning
//   IDLE  | nothing shifting, o_a_valid low
//   SHIFT | emitting bit bitcnt of the loaded word (or its parity bit)
module stream_serializer
   import ser_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_word,
   input  logic             i_word_valid,
   output logic             o_word_ready,
   output logic             o_a,
   output logic             o_a_valid,
   output logic             o_last,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_words_sent
);

   localparam int BC_W = bitcnt_w(WIDTH);
`ifdef SER_PARITY_EN
   localparam bit PAR_EN   = 1'b1;
   localparam int LAST_IDX = WIDTH;
`else
   localparam bit PAR_EN   = 1'b0;
   localparam int LAST_IDX = WIDTH - 1;
`endif
   localparam logic [BC_W-1:0] LAST_CNT = BC_W'(LAST_IDX);
   localparam logic [BC_W-1:0] PAR_CNT  = BC_W'(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
   logic             par_q, par_d;
   logic             a_q, a_d;
   logic             a_valid_q, a_valid_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] words_q, words_d;

   logic             pend_load, pend_take, pend_valid, pend_ready;
   logic [WIDTH-1:0] pend_data;
   logic             xfer, at_last;

   ser_pend_slot #(.WIDTH(WIDTH)) u_pend (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (pend_load),
      .i_data  (i_word),
      .i_take  (pend_take),
      .o_data  (pend_data),
      .o_valid (pend_valid),
      .o_ready (pend_ready)
   );

   assign o_word_ready = i_rst & pend_ready;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bitcnt_d  = bitcnt_q;
      par_d     = par_q;
      words_d   = words_q;
      pend_load = 1'b0;
      pend_take = 1'b0;
      xfer      = i_word_valid & o_word_ready;
      at_last   = (state_q == SHIFT) && (bitcnt_q == LAST_CNT);

      case (state_q)
         IDLE: begin
            if (xfer) begin
               state_d  = SHIFT;
               shift_d  = i_word;
               par_d    = ^i_word;
               bitcnt_d = '0;
            end
         end
         SHIFT: begin
            if (at_last) begin
               words_d  = words_q + 1'b1;
               bitcnt_d = '0;
               // Pending word wins over a same-edge bypass; both keep the stream gapless.
               if (pend_valid) begin
                  shift_d   = pend_data;
                  par_d     = ^pend_data;
                  pend_take = 1'b1;
               end else if (xfer) begin
                  shift_d = i_word;
                  par_d   = ^i_word;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               shift_d  = {shift_q[WIDTH-2:0], 1'b0};
               bitcnt_d = bitcnt_q + 1'b1;
               pend_load = xfer;
            end
         end
         default: state_d = IDLE;
      endcase

      a_valid_d = (state_d == SHIFT);
      a_d       = a_valid_d & ((PAR_EN && bitcnt_d == PAR_CNT) ? par_d : shift_d[WIDTH-1]);
      last_d    = a_valid_d && (bitcnt_d == LAST_CNT);
      busy_d    = a_valid_d | (pend_valid & ~pend_take) | pend_load;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bitcnt_q  <= '0;
         par_q     <= 1'b0;
         a_q       <= 1'b0;
         a_valid_q <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         words_q   <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bitcnt_q  <= bitcnt_d;
         par_q     <= par_d;
         a_q       <= a_d;
         a_valid_q <= a_valid_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         words_q   <= words_d;
      end
   end

   assign o_a          = a_q;
   assign o_a_valid    = a_valid_q;
   assign o_last       = last_q;
   assign o_busy       = busy_q;
   assign o_words_sent = words_q;

endmodule
